// File: rtl/serial_sub_unit_if.sv
// Start/busy/done handshake plus operand and result bundle for serial_sub_unit.
// The requester holds the master side and the arithmetic unit holds the slave side.
interface serial_sub_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin, signed_mode,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin, signed_mode,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub_unit.sv
// Multi-cycle subtractor diff = a - b - bin, DIGIT bits per clock with a registered borrow.
// Results and flags change only on the final RUN edge, which also pulses done.
module serial_sub_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_unit_if.slave bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW    = DIGIT + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_sub_unit: DIGIT must lie in 1..WIDTH and divide WIDTH");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_accept;
    logic                   w_last;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_borrow;
    logic                   r_signed;
    logic [CNT_W-1:0]       r_cnt;

    logic                   r_done;
    logic [WIDTH-1:0]       r_diff;
    logic                   r_bout;
    logic                   r_ovf;

    logic [DIGIT:0]         w_dig;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_a_next;
    logic                   w_msb_bin;

    // Top bit of the DIGIT+1 wide difference is the borrow out of this digit.
    assign w_dig = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - DW'(r_borrow);

    // r_a doubles as the result accumulator: result digits enter at the top
    // as the minuend drains out of the bottom, so after NDIG shifts it holds diff.
    assign w_cat    = {w_dig[DIGIT-1:0], r_a};
    assign w_a_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    // Borrow into the digit MSB, recovered from d = a ^ b ^ borrow_in at that bit.
    assign w_msb_bin = w_dig[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_borrow <= bus.bin;
                r_signed <= bus.signed_mode;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_a      <= w_a_next;
                r_b      <= r_b >> DIGIT;
                r_borrow <= w_dig[DIGIT];
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_diff <= w_a_next;
                    r_bout <= w_dig[DIGIT];
                    r_ovf  <= r_signed ? (w_msb_bin ^ w_dig[DIGIT]) : w_dig[DIGIT];
                end
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_sub_unit.sv
// Self-checking bench: three 8-bit instances (DIGIT 1, 4, 8) share clock, reset and stimulus;
// directed cases run against DIGIT=4, random vectors against all three versus an arithmetic model.
module tb_serial_sub_unit;
    logic       clk;
    logic       rst;
    logic       t_start;
    logic [7:0] t_a;
    logic [7:0] t_b;
    logic       t_bin;
    logic       t_sm;

    int n_checks = 0;
    int n_errors = 0;

    serial_sub_unit_if #(.WIDTH(8)) bus_d1 ();
    serial_sub_unit_if #(.WIDTH(8)) bus_d4 ();
    serial_sub_unit_if #(.WIDTH(8)) bus_d8 ();

    assign bus_d1.start = t_start;
    assign bus_d1.a = t_a;
    assign bus_d1.b = t_b;
    assign bus_d1.bin = t_bin;
    assign bus_d1.signed_mode = t_sm;
    assign bus_d4.start = t_start;
    assign bus_d4.a = t_a;
    assign bus_d4.b = t_b;
    assign bus_d4.bin = t_bin;
    assign bus_d4.signed_mode = t_sm;
    assign bus_d8.start = t_start;
    assign bus_d8.a = t_a;
    assign bus_d8.b = t_b;
    assign bus_d8.bin = t_bin;
    assign bus_d8.signed_mode = t_sm;

    serial_sub_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(bus_d1.slave));
    serial_sub_unit #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(bus_d4.slave));
    serial_sub_unit #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(bus_d8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, both as unsigned and as signed values.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  input logic sm, output logic [7:0] d, output logic bo,
                                  output logic ov);
        int u;
        int s;
        u  = int'(a) - int'(b) - int'(bin);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = u[7:0];
        bo = (u < 0);
        ov = sm ? ((s < -128) || (s > 127)) : bo;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic sm);
        t_a   = a;
        t_b   = b;
        t_bin = bin;
        t_sm  = sm;
    endtask

    task automatic scramble();
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Called on the falling edge after an accept edge; counts edges until done on the DIGIT=4 unit.
    task automatic wait_d4(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus_d4.done !== 1'b1 && lat < 20) begin
            if (bus_d4.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        check("d4_done_seen", 32'(bus_d4.done), 32'd1);
    endtask

    task automatic op_d4(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic sm, input logic [7:0] ed,
                         input logic ebo, input logic eov);
        int lat;
        int bn;
        @(negedge clk);
        drive(a, b, bin, sm);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        scramble();
        wait_d4(lat, bn);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_busy_cycles"}, bn, 2);
        check({tag, "_busy_at_done"}, 32'(bus_d4.busy), 32'd0);
        check({tag, "_diff"}, 32'(bus_d4.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus_d4.bout), 32'(ebo));
        check({tag, "_ovf"}, 32'(bus_d4.ovf), 32'(eov));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_d4.done), 32'd0);
    endtask

    initial begin
        int lat;
        int bn;
        int n_done;
        int last;
        logic [7:0] ra, rb, ed;
        logic rbin, rsm, ebo, eov;
        logic seen1, seen4, seen8;

        rst     = 1'b1;
        t_start = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus_d4.busy), 32'd0);
        check("rst_done", 32'(bus_d4.done), 32'd0);
        check("rst_diff", 32'(bus_d4.diff), 32'd0);
        check("rst_bout", 32'(bus_d4.bout), 32'd0);
        check("rst_ovf", 32'(bus_d4.ovf), 32'd0);

        op_d4("basic", 8'h5A, 8'h23, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0);
        op_d4("uns_bin", 8'h10, 8'h20, 1'b1, 1'b0, 8'hEF, 1'b1, 1'b1);
        op_d4("sgn_bin", 8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b1, 1'b0);
        op_d4("sgn_minneg", 8'h80, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1);
        op_d4("sgn_maxpos", 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        op_d4("sgn_neg", 8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

        // start held high: one accepted operation every NDIG+1 = 3 cycles
        @(negedge clk);
        drive(8'h5A, 8'h23, 1'b0, 1'b0);
        t_start = 1'b1;
        n_done  = 0;
        last    = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (bus_d4.done === 1'b1) begin
                if (n_done > 0) check("hold_interval", cyc - last, 3);
                check("hold_diff", 32'(bus_d4.diff), 32'h37);
                last = cyc;
                n_done++;
            end
        end
        t_start = 1'b0;
        check("hold_count", n_done, 5);
        repeat (4) @(negedge clk);

        // start with new operands while busy is ignored
        @(negedge clk);
        drive(8'h5A, 8'h23, 1'b0, 1'b0);
        t_start = 1'b1;
        @(negedge clk);
        check("ign_busy", 32'(bus_d4.busy), 32'd1);
        drive(8'hFF, 8'h01, 1'b1, 1'b1);
        @(negedge clk);
        t_start = 1'b0;
        wait_d4(lat, bn);
        check("ign_latency", lat, 1);
        check("ign_diff", 32'(bus_d4.diff), 32'h37);
        check("ign_ovf", 32'(bus_d4.ovf), 32'd0);
        @(negedge clk);
        check("ign_not_queued", 32'(bus_d4.busy), 32'd0);

        // start during the done cycle is accepted on the very next edge
        drive(8'h10, 8'h20, 1'b1, 1'b0);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        wait_d4(lat, bn);
        check("dc_first_diff", 32'(bus_d4.diff), 32'hEF);
        drive(8'h03, 8'h01, 1'b0, 1'b0);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        check("dc_accepted", 32'(bus_d4.busy), 32'd1);
        scramble();
        wait_d4(lat, bn);
        check("dc_latency", lat, 2);
        check("dc_second_diff", 32'(bus_d4.diff), 32'h02);
        @(negedge clk);

        // reset in the first RUN cycle abandons the operation
        @(negedge clk);
        drive(8'h5A, 8'h23, 1'b0, 1'b0);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_busy", 32'(bus_d4.busy), 32'd0);
        check("rr_done", 32'(bus_d4.done), 32'd0);
        check("rr_diff", 32'(bus_d4.diff), 32'd0);
        check("rr_bout", 32'(bus_d4.bout), 32'd0);
        check("rr_ovf", 32'(bus_d4.ovf), 32'd0);
        n_done = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus_d4.done === 1'b1) n_done++;
        end
        check("rr_no_done", n_done, 0);
        op_d4("rr_after", 8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1);

        // random vectors against all three digit sizes
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 1000; v++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom_range(0, 1));
            rsm  = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, rsm, ed, ebo, eov);
            @(negedge clk);
            drive(ra, rb, rbin, rsm);
            t_start = 1'b1;
            @(negedge clk);
            t_start = 1'b0;
            scramble();
            check("rnd_busy_d1", 32'(bus_d1.busy), 32'd1);
            check("rnd_busy_d8", 32'(bus_d8.busy), 32'd1);
            seen1 = 1'b0;
            seen4 = 1'b0;
            seen8 = 1'b0;
            lat   = 0;
            while (!(seen1 && seen4 && seen8) && lat <= 12) begin
                if (bus_d1.done === 1'b1 && !seen1) begin
                    seen1 = 1'b1;
                    check($sformatf("rnd%0d_d1_latency", v), lat, 8);
                    check($sformatf("rnd%0d_d1_diff", v), 32'(bus_d1.diff), 32'(ed));
                    check($sformatf("rnd%0d_d1_bout", v), 32'(bus_d1.bout), 32'(ebo));
                    check($sformatf("rnd%0d_d1_ovf", v), 32'(bus_d1.ovf), 32'(eov));
                end
                if (bus_d4.done === 1'b1 && !seen4) begin
                    seen4 = 1'b1;
                    check($sformatf("rnd%0d_d4_latency", v), lat, 2);
                    check($sformatf("rnd%0d_d4_diff", v), 32'(bus_d4.diff), 32'(ed));
                    check($sformatf("rnd%0d_d4_bout", v), 32'(bus_d4.bout), 32'(ebo));
                    check($sformatf("rnd%0d_d4_ovf", v), 32'(bus_d4.ovf), 32'(eov));
                end
                if (bus_d8.done === 1'b1 && !seen8) begin
                    seen8 = 1'b1;
                    check($sformatf("rnd%0d_d8_latency", v), lat, 1);
                    check($sformatf("rnd%0d_d8_diff", v), 32'(bus_d8.diff), 32'(ed));
                    check($sformatf("rnd%0d_d8_bout", v), 32'(bus_d8.bout), 32'(ebo));
                    check($sformatf("rnd%0d_d8_ovf", v), 32'(bus_d8.ovf), 32'(eov));
                end
                @(negedge clk);
                lat++;
            end
            check("rnd_all_done", 32'({seen1, seen4, seen8}), 32'h7);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_unit.md
Name: serial_sub_unit

Overview:
Parametrised multi-cycle N-bit subtractor computing diff = a - b - bin. It processes DIGIT bits per clock with a registered borrow chain, and uses a start/busy/done handshake. It extends the single-bit full-subtractor cell to arbitrary width, selectable signed/unsigned overflow, and area-vs-latency trade via DIGIT. It is the arithmetic unit used wherever wide subtraction is needed without a wide combinational borrow path.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥ 1.
DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT must be 0, else elaboration error.
(Derived) NDIG = WIDTH/DIGIT, the number of RUN cycles per operation.

Ports:
clk          input   1      rising-edge clock
rst          input   1      synchronous reset, active-high
start        input   1      request; sampled only in IDLE
a            input   WIDTH  minuend; captured at accepted start
b            input   WIDTH  subtrahend; captured at accepted start
bin          input   1      borrow-in; captured at accepted start
signed_mode  input   1      1 = two's-complement overflow, 0 = unsigned; captured at accepted start
busy         output  1      operation in progress
done         output  1      one-cycle pulse: results valid/updated
diff         output  WIDTH  result a - b - bin mod 2^WIDTH
bout         output  1      borrow-out of MSB
ovf          output  1      overflow flag per captured mode

Behaviour:
- Reset (rst=1 at edge): state→IDLE; busy, done, diff, bout, ovf → 0; digit counter, operand shift registers and internal borrow → 0. rst dominates start and any in-flight operation, which is abandoned with no done pulse.
- State machine:
  - IDLE: if start=1, capture a, b, bin, signed_mode; set borrow←bin, cnt←0, busy←1; go to RUN. If start=0, stay.
  - RUN: each edge computes {borrow', d} = a_dig - b_dig - borrow on the current low DIGIT bits. It shifts the result digit into the result register, shifts the operands right by DIGIT, and sets cnt←cnt+1.
  - Last RUN edge (cnt = NDIG-1): write diff, bout = final borrow, ovf; done←1, busy←0; go to IDLE.
- There is no separate DONE state. done is high for exactly one cycle, during which the unit is already IDLE.
- Timing: start accepted at edge E0. busy is high after E0 through edge E(NDIG). done and new results are visible after E(NDIG).
  - A start present during the done cycle is accepted at E(NDIG+1).
  - Maximum throughput is one operation per NDIG+1 cycles.
- start while busy=1 is ignored: not queued, and the captured operands are unchanged. Input changes after capture have no effect.
- diff, bout and ovf update only at completion and hold until the next completion or reset. Partial results are never exposed.
- Overflow:
  - signed_mode=0: ovf = bout.
  - signed_mode=1: ovf = (borrow into MSB) XOR (borrow out of MSB). The last digit must expose the borrow into bit WIDTH-1 internally. This is correct including bin=1 cases such as a = most-negative value.
- DIGIT = WIDTH gives a one-RUN-cycle operation (NDIG=1). DIGIT = 1 gives a pure bit-serial subtractor.
- Borrow arithmetic per digit is unsigned DIGIT-bit with a 1-bit borrow. No X propagation from uncaptured inputs.

Test Plan:
1. WIDTH=8, DIGIT=4, unsigned: a=0x5A, b=0x23, bin=0, start pulse → done exactly 2 cycles after the capture edge; diff=0x37, bout=0, ovf=0; busy high 2 cycles.
2. Same config: a=0x10, b=0x20, bin=1 → diff=0xEF, bout=1, ovf=1 (unsigned); then signed_mode=1 with the same operands → ovf=0.
3. Signed: a=0x80, b=0x00, bin=1 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1. Then a=0xFF, b=0x01 → diff=0xFE, ovf=0.
4. Handshake: start held high continuously → operations accepted every 3 cycles. A start pulse with different operands mid-RUN is ignored, and the result matches the first operands. A start in the done cycle is accepted on the next edge.
5. rst asserted during RUN cycle 1 → next cycle busy=0, done=0, diff=0, bout=0, ovf=0, with no done pulse. A subsequent start a=0x03, b=0x05 → diff=0xFE, bout=1.
6. DIGIT=1, WIDTH=8 and DIGIT=8, WIDTH=8: 1000 random a/b/bin/signed_mode vectors vs. a behavioural model → all match; latency 8 and 1 respectively.
